// File: rtl/menu_pkg.sv
// Shared types and channel indices for the front-panel menu controller.
package menu_pkg;

   typedef enum logic [1:0] {EV_IDLE, EV_HELD, EV_LONG} btn_ev_t;

   typedef enum logic [1:0] {ADC_PWM, ADC_R2R, ADC_SAR, ADC_XADC} adc_sel_t;

   localparam int CH_ADC   = 0;
   localparam int CH_SCALE = 1;
   localparam int CH_RADIX = 2;
   localparam int CH_MODE  = 3;

endpackage

// File: rtl/menu_btn_event.sv
// Per-button press classifier: rising-edge detect, hold counter, short/long event pulses.
//
// state   | meaning
// EV_IDLE | waiting for a fresh rising edge on btn
// EV_HELD | button held, counting toward a long press
// EV_LONG | long press already reported, waiting for release
module menu_btn_event
   import menu_pkg::*;
#(
   parameter int LONG_CYCLES = 50_000_000,
   parameter int CNT_W       = $clog2(LONG_CYCLES + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic short_p,
   output logic long_p
);

   localparam logic [CNT_W-1:0] CNT_LONG = CNT_W'(LONG_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   btn_ev_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             btn_prev;

   // btn_prev resets high so a button held through reset needs a full release first
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= EV_IDLE;
         cnt_q    <= '0;
         btn_prev <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         btn_prev <= btn;
      end
   end

   // Events are Mealy outputs so the top registers sel on the deciding edge
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      short_p = 1'b0;
      long_p  = 1'b0;
      case (state_q)
         EV_IDLE: begin
            if (btn && !btn_prev) begin
               state_d = EV_HELD;
               cnt_d   = CNT_ONE;
            end
         end
         EV_HELD: begin
            if (!btn) begin
               short_p = 1'b1;
               state_d = EV_IDLE;
            end else if (cnt_q >= CNT_LONG - CNT_ONE) begin
               long_p  = 1'b1;
               state_d = EV_LONG;
               cnt_d   = CNT_LONG;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         EV_LONG: begin
            if (!btn) state_d = EV_IDLE;
         end
         default: state_d = EV_IDLE;
      endcase
   end

endmodule

// File: rtl/menu_ctrl_param.sv
// Front-panel menu controller: per-channel wrap-around selection registers stepped by
// short (forward) and long (back) presses, with lock gating and ch0 one-hot ADC enables.
module menu_ctrl_param
   import menu_pkg::*;
#(
   parameter int                   NUM_BTN     = 4,
   parameter int                   SEL_W       = 2,
   parameter logic [4*NUM_BTN-1:0] MODE_COUNTS = {4'd3, 4'd2, 4'd3, 4'd4},
   parameter int                   LONG_CYCLES = 50_000_000,
   parameter int                   CNT_W       = $clog2(LONG_CYCLES + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_BTN-1:0]       btn_in,
   input  logic                     lock,
   output logic [NUM_BTN*SEL_W-1:0] sel,
   output logic [NUM_BTN-1:0]       sel_changed,
   output logic [NUM_BTN-1:0]       long_evt,
   output logic [2**SEL_W-1:0]      ch0_en
);

   localparam int EN_W = 2**SEL_W;
   localparam int N0   = int'(MODE_COUNTS[4*CH_ADC +: 4]);

   logic [NUM_BTN-1:0]       short_p, long_p;
   logic [NUM_BTN*SEL_W-1:0] sel_d;
   logic [NUM_BTN-1:0]       chg_d;
   logic [EN_W-1:0]          ch0_en_d;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
      localparam int               N    = int'(MODE_COUNTS[4*g +: 4]);
      localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

      logic [SEL_W-1:0] cur, nxt;
      logic             chg;

      menu_btn_event #(
         .LONG_CYCLES (LONG_CYCLES),
         .CNT_W       (CNT_W)
      ) u_evt (
         .clk     (clk),
         .reset   (reset),
         .btn     (btn_in[g]),
         .short_p (short_p[g]),
         .long_p  (long_p[g])
      );

      assign cur = sel[g*SEL_W +: SEL_W];

      // Out-of-range recovery is not lock-gated; it is a correction, not a user event
      always_comb begin
         nxt = cur;
         chg = 1'b0;
         if (int'(cur) >= N) begin
            nxt = '0;
            chg = 1'b1;
         end else if (!lock && N > 1) begin
            if (short_p[g]) begin
               nxt = (cur == LAST) ? '0 : cur + SEL_W'(1);
               chg = 1'b1;
            end else if (long_p[g]) begin
               nxt = (cur == '0) ? LAST : cur - SEL_W'(1);
               chg = 1'b1;
            end
         end
      end

      assign sel_d[g*SEL_W +: SEL_W] = nxt;
      assign chg_d[g]                = chg;
   end

   always_comb begin
      ch0_en_d = '0;
      for (int b = 0; b < EN_W; b++) begin
         if (b < N0 && sel_d[CH_ADC*SEL_W +: SEL_W] == SEL_W'(b)) ch0_en_d[b] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sel         <= '0;
         sel_changed <= '0;
         long_evt    <= '0;
         ch0_en      <= EN_W'(1);
      end else begin
         sel         <= sel_d;
         sel_changed <= chg_d;
         long_evt    <= long_p;
         ch0_en      <= ch0_en_d;
      end
   end

endmodule

// File: tb/tb_menu_ctrl_param.sv
// Directed bench for menu_ctrl_param with a short long-press threshold.
module tb_menu_ctrl_param;

   localparam int NUM_BTN = 4;
   localparam int SEL_W   = 2;
   localparam int LONG_C  = 8;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NUM_BTN-1:0]       btn_in;
   logic                     lock;
   logic [NUM_BTN*SEL_W-1:0] sel;
   logic [NUM_BTN-1:0]       sel_changed;
   logic [NUM_BTN-1:0]       long_evt;
   logic [2**SEL_W-1:0]      ch0_en;

   int n_checks = 0;
   int n_fail   = 0;
   int pulse_cnt [NUM_BTN];
   int long_cnt  [NUM_BTN];

   menu_ctrl_param #(
      .NUM_BTN     (NUM_BTN),
      .SEL_W       (SEL_W),
      .MODE_COUNTS (16'h3234),
      .LONG_CYCLES (LONG_C),
      .CNT_W       (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_in      (btn_in),
      .lock        (lock),
      .sel         (sel),
      .sel_changed (sel_changed),
      .long_evt    (long_evt),
      .ch0_en      (ch0_en)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_BTN; i++) begin
         pulse_cnt[i] += int'(sel_changed[i]);
         long_cnt[i]  += int'(long_evt[i]);
      end
   endtask

   task automatic clr_cnt();
      for (int i = 0; i < NUM_BTN; i++) begin
         pulse_cnt[i] = 0;
         long_cnt[i]  = 0;
      end
   endtask

   function automatic logic [SEL_W-1:0] sel_ch(input int i);
      return sel[i*SEL_W +: SEL_W];
   endfunction

   // Drive the masked buttons high for 'hold' samples, then release and take the release edge
   task automatic press(input logic [NUM_BTN-1:0] mask, input int hold);
      btn_in = btn_in | mask;
      repeat (hold) step();
      btn_in = btn_in & ~mask;
      step();
   endtask

   initial begin
      logic [1:0] exp_sel;
      reset  = 1'b1;
      btn_in = '0;
      lock   = 1'b0;
      clr_cnt();
      repeat (3) step();
      reset = 1'b0;
      step();

      // 1: reset state
      check("rst_sel", 32'(sel), 32'h0);
      check("rst_ch0_en", 32'(ch0_en), 32'h1);
      check("rst_chg", 32'(sel_changed), 32'h0);
      check("rst_long", 32'(long_evt), 32'h0);

      // 2: four short presses on btn0
      clr_cnt();
      for (int k = 0; k < 4; k++) begin
         press(4'b0001, 3);
         exp_sel = 2'((k + 1) % 4);
         check("s2_sel0", 32'(sel_ch(0)), 32'(exp_sel));
         check("s2_ch0_en", 32'(ch0_en), 32'(4'b0001 << exp_sel));
         check("s2_chg_on_release", 32'(sel_changed), 32'h1);
         step();
         check("s2_chg_one_cycle", 32'(sel_changed), 32'h0);
      end
      check("s2_pulse_count", 32'(pulse_cnt[0]), 32'd4);

      // 3: long hold on btn1 (N=3) from 0
      clr_cnt();
      btn_in[1] = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (c == 7) check("s3_sel1_before", 32'(sel_ch(1)), 32'h0);
         if (c == 8) begin
            check("s3_sel1_long", 32'(sel_ch(1)), 32'h2);
            check("s3_long_evt", 32'(long_evt), 32'h2);
            check("s3_chg_long", 32'(sel_changed), 32'h2);
         end
      end
      btn_in[1] = 1'b0;
      step();
      check("s3_sel1_release", 32'(sel_ch(1)), 32'h2);
      check("s3_chg_release", 32'(sel_changed), 32'h0);
      check("s3_long_count", 32'(long_cnt[1]), 32'd1);
      check("s3_pulse_count", 32'(pulse_cnt[1]), 32'd1);

      // 4: simultaneous short on btn2 and btn3, then btn2 again
      clr_cnt();
      press(4'b1100, 2);
      check("s4_sel2_a", 32'(sel_ch(2)), 32'h1);
      check("s4_sel3", 32'(sel_ch(3)), 32'h1);
      check("s4_chg_both", 32'(sel_changed), 32'hC);
      step();
      press(4'b0100, 2);
      check("s4_sel2_b", 32'(sel_ch(2)), 32'h0);
      check("s4_chg2", 32'(sel_changed), 32'h4);
      check("s4_sel_all", 32'(sel), 32'h48);

      // 5: lock swallows events, no replay after unlock
      step();
      clr_cnt();
      lock = 1'b1;
      press(4'b1111, 3);
      check("s5_sel_locked", 32'(sel), 32'h48);
      check("s5_chg_locked", 32'(sel_changed), 32'h0);
      step();
      lock = 1'b0;
      repeat (4) step();
      check("s5_sel_unlock", 32'(sel), 32'h48);
      check("s5_no_pulses", 32'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 32'd0);
      press(4'b1000, 3);
      check("s5_sel3_after", 32'(sel_ch(3)), 32'h2);
      check("s5_sel_after", 32'(sel), 32'h88);

      // 6: reset mid-hold on btn0
      step();
      btn_in[0] = 1'b1;
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      clr_cnt();
      repeat (20) step();
      check("s6_sel_held", 32'(sel), 32'h0);
      check("s6_ch0_en_held", 32'(ch0_en), 32'h1);
      check("s6_no_events", 32'(pulse_cnt[0] + long_cnt[0]), 32'd0);
      btn_in[0] = 1'b0;
      repeat (2) step();
      press(4'b0001, 3);
      check("s6_sel0_after", 32'(sel_ch(0)), 32'h1);
      check("s6_ch0_en_after", 32'(ch0_en), 32'h2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
